// File: rtl/segment_transition_ctrl_pkg.sv
// Shared definitions for the segment transition controller: transition mode
// codes, controller FSM states and the "repeat forever" marker.
package segment_transition_ctrl_pkg;

    localparam logic [7:0] TRANSITION_MODE_SYNC_IDX  = 8'h00;
    localparam logic [7:0] TRANSITION_MODE_SYS_TIME  = 8'h01;
    localparam logic [7:0] TRANSITION_MODE_GPIO      = 8'h02;
    localparam logic [7:0] TRANSITION_MODE_EXT       = 8'hF0;
    localparam logic [7:0] TRANSITION_MODE_IMMEDIATE = 8'hFF;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_IDX  = 2'd1,
        WAIT_TIME = 2'd2,
        WAIT_GPIO = 2'd3
    } fsm_state_t;

    // All-ones repetition count means the segment loops forever.
    // Sliced down to the repetition width at the point of use.
    localparam logic [63:0] REP_INFINITE = '1;

    // True for the mode codes the controller understands.
    function automatic logic mode_is_valid(input logic [7:0] mode);
        return (mode == TRANSITION_MODE_SYNC_IDX)  ||
               (mode == TRANSITION_MODE_SYS_TIME)  ||
               (mode == TRANSITION_MODE_GPIO)      ||
               (mode == TRANSITION_MODE_EXT)       ||
               (mode == TRANSITION_MODE_IMMEDIATE);
    endfunction

endpackage

// File: rtl/segment_transition_ctrl_gpio_edge_sync.sv
// Two-flop synchroniser for asynchronous trigger pins followed by a
// rising-edge detector. rise[i] is high for one cycle per synchronised edge.
module gpio_edge_sync #(
    parameter int GPIO_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [GPIO_W-1:0] pin,
    output logic [GPIO_W-1:0] rise
);

    logic [GPIO_W-1:0] meta;
    logic [GPIO_W-1:0] sync;
    logic [GPIO_W-1:0] sync_d;

    // Synchroniser chain plus one delayed copy for the edge compare.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta   <= '0;
            sync   <= '0;
            sync_d <= '0;
        end else begin
            meta   <= pin;
            sync   <= meta;
            sync_d <= sync;
        end
    end

    assign rise = sync & ~sync_d;

endmodule

// File: rtl/segment_transition_ctrl.sv
// Segment transition controller: decides the cycle on which the active read
// segment changes, according to the requested transition mode, and counts
// completed loops of the active segment against its repetition setting.
module segment_transition_ctrl
    import segment_transition_ctrl_pkg::*;
#(
    parameter int NUM_SEGMENTS = 4,
    parameter int SEG_W        = $clog2(NUM_SEGMENTS),
    parameter int REP_W        = 32,
    parameter int GPIO_W       = 4
) (
    input  logic                                CLK,
    input  logic                                RST,
    input  logic                                UPDATE,
    input  logic [SEG_W-1:0]                    REQ_RD_SEGMENT,
    input  logic [7:0]                          TRANSITION_MODE,
    input  logic [63:0]                         TRANSITION_VALUE,
    input  logic [NUM_SEGMENTS-1:0][REP_W-1:0]  REP,
    input  logic [63:0]                         SYS_TIME,
    input  logic [GPIO_W-1:0]                   GPIO_IN,
    input  logic                                LOOP_END,
    output logic [SEG_W-1:0]                    SEGMENT,
    output logic                                STOP,
    output logic                                BUSY,
    output logic [REP_W-1:0]                    LOOP_CNT,
    output logic                                SWAPPED,
    output logic                                ERR
);

    localparam int GSEL_W = (GPIO_W > 1) ? $clog2(GPIO_W) : 1;

    fsm_state_t        state;
    logic [SEG_W-1:0]  target;
    logic [63:0]       time_val;
    logic [GSEL_W-1:0] gpio_sel;
    logic              ext_latched;
    logic [GPIO_W-1:0] gpio_rise;

    logic              req_ok, req_direct, cond_met, ext_next;
    logic              at_rep, count_loop, auto_adv, do_swap;
    logic [REP_W-1:0]  rep_cur;
    logic [SEG_W-1:0]  seg_next, swap_seg;

    gpio_edge_sync #(.GPIO_W(GPIO_W)) u_gpio_sync (
        .clk  (CLK),
        .rst  (RST),
        .pin  (GPIO_IN),
        .rise (gpio_rise)
    );

    // Request acceptance, pending-condition evaluation and loop accounting.
    // An accepted request always overrides a pending condition in the same
    // cycle; a loop end that coincides with a swap is not counted.
    always_comb begin
        req_ok     = UPDATE && mode_is_valid(TRANSITION_MODE) &&
                     (int'(REQ_RD_SEGMENT) < NUM_SEGMENTS);
        req_direct = req_ok && ((TRANSITION_MODE == TRANSITION_MODE_EXT) ||
                                (TRANSITION_MODE == TRANSITION_MODE_IMMEDIATE));
        cond_met   = 1'b0;
        case (state)
            WAIT_IDX:  cond_met = LOOP_END;
            WAIT_TIME: cond_met = (SYS_TIME >= time_val);
            WAIT_GPIO: cond_met = (int'(gpio_sel) < GPIO_W) && gpio_rise[gpio_sel];
            default:   cond_met = 1'b0;
        endcase
        ext_next   = req_ok ? (TRANSITION_MODE == TRANSITION_MODE_EXT) : ext_latched;
        rep_cur    = REP[SEGMENT];
        at_rep     = (rep_cur != REP_INFINITE[REP_W-1:0]) && (LOOP_CNT == rep_cur);
        count_loop = LOOP_END && !STOP && !req_direct && (req_ok || !cond_met);
        auto_adv   = count_loop && at_rep && ext_next;
        do_swap    = req_direct || (!req_ok && cond_met) || auto_adv;
        seg_next   = (int'(SEGMENT) == NUM_SEGMENTS - 1) ? '0 : SEGMENT + 1'b1;
        swap_seg   = req_direct ? REQ_RD_SEGMENT : (auto_adv ? seg_next : target);
    end

    // Pending-request state: captured on an accepted update, cleared on swap.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= IDLE;
            target      <= '0;
            time_val    <= '0;
            gpio_sel    <= '0;
            ext_latched <= 1'b0;
        end else if (req_ok) begin
            ext_latched <= (TRANSITION_MODE == TRANSITION_MODE_EXT);
            target      <= REQ_RD_SEGMENT;
            time_val    <= TRANSITION_VALUE;
            gpio_sel    <= TRANSITION_VALUE[GSEL_W-1:0];
            case (TRANSITION_MODE)
                TRANSITION_MODE_SYNC_IDX: state <= WAIT_IDX;
                TRANSITION_MODE_SYS_TIME: state <= WAIT_TIME;
                TRANSITION_MODE_GPIO:     state <= WAIT_GPIO;
                default:                  state <= IDLE;
            endcase
        end else if (cond_met) begin
            state <= IDLE;
        end
    end

    // Sampler-facing outputs: active segment, loop counter, stop and pulses.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            SEGMENT  <= '0;
            LOOP_CNT <= '0;
            STOP     <= 1'b0;
            SWAPPED  <= 1'b0;
            ERR      <= 1'b0;
        end else begin
            SWAPPED <= do_swap;
            ERR     <= UPDATE && !req_ok;
            if (do_swap) begin
                SEGMENT  <= swap_seg;
                LOOP_CNT <= '0;
                STOP     <= 1'b0;
            end else if (count_loop) begin
                if (LOOP_CNT != {REP_W{1'b1}})
                    LOOP_CNT <= LOOP_CNT + 1'b1;
                if (at_rep)
                    STOP <= 1'b1;
            end
        end
    end

    assign BUSY = (state != IDLE);

endmodule

// File: tb/tb_segment_transition_ctrl.sv
// Self-checking bench for segment_transition_ctrl: directed scenarios plus a
// randomized run compared cycle by cycle against a behavioural model.
module tb_segment_transition_ctrl;

    localparam int NSEG  = 4;
    localparam int SEG_W = 2;
    localparam int REP_W = 8;
    localparam int GW    = 4;

    localparam logic [7:0] M_SYNC = 8'h00, M_TIME = 8'h01, M_GPIO = 8'h02;
    localparam logic [7:0] M_EXT  = 8'hF0, M_IMM  = 8'hFF;

    logic                           CLK = 1'b0;
    logic                           RST = 1'b1;
    logic                           UPDATE = 1'b0;
    logic [SEG_W-1:0]               REQ_RD_SEGMENT = '0;
    logic [7:0]                     TRANSITION_MODE = '0;
    logic [63:0]                    TRANSITION_VALUE = '0;
    logic [NSEG-1:0][REP_W-1:0]     REP = '1;
    logic [63:0]                    SYS_TIME = 64'd1000;
    logic [GW-1:0]                  GPIO_IN = '0;
    logic                           LOOP_END = 1'b0;
    logic [SEG_W-1:0]               SEGMENT;
    logic                           STOP, BUSY, SWAPPED, ERR;
    logic [REP_W-1:0]               LOOP_CNT;

    int n_checks = 0;
    int n_fail   = 0;

    segment_transition_ctrl #(
        .NUM_SEGMENTS(NSEG), .SEG_W(SEG_W), .REP_W(REP_W), .GPIO_W(GW)
    ) dut (
        .CLK(CLK), .RST(RST), .UPDATE(UPDATE), .REQ_RD_SEGMENT(REQ_RD_SEGMENT),
        .TRANSITION_MODE(TRANSITION_MODE), .TRANSITION_VALUE(TRANSITION_VALUE),
        .REP(REP), .SYS_TIME(SYS_TIME), .GPIO_IN(GPIO_IN), .LOOP_END(LOOP_END),
        .SEGMENT(SEGMENT), .STOP(STOP), .BUSY(BUSY), .LOOP_CNT(LOOP_CNT),
        .SWAPPED(SWAPPED), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    // ---------------- behavioural model ----------------
    // pending: 0 none, 1 wait loop end, 2 wait time, 3 wait pin edge
    int          m_seg, m_cnt, m_pend, m_pseg;
    bit          m_stop, m_ext, m_swp, m_err;
    logic [63:0] m_pval;
    logic [GW-1:0] pin_hist[$];   // pin samples at past edges, newest first

    task automatic model_reset();
        m_seg = 0; m_cnt = 0; m_pend = 0; m_pseg = 0; m_pval = '0;
        m_stop = 0; m_ext = 0; m_swp = 0; m_err = 0;
        pin_hist = {4'b0, 4'b0, 4'b0, 4'b0};
    endtask

    task automatic model_step();
        logic [GW-1:0] edge_seen;
        bit valid, do_swap, count, cond, at_rep;
        int tgt, rep;
        // a pin level takes two edges to synchronise, the third edge acts on it
        edge_seen = pin_hist[1] & ~pin_hist[2];
        m_swp = 0; m_err = 0; do_swap = 0; count = 0; tgt = 0; cond = 0;
        valid = UPDATE && (TRANSITION_MODE inside {M_SYNC, M_TIME, M_GPIO, M_EXT, M_IMM})
                && (int'(REQ_RD_SEGMENT) < NSEG);
        if (UPDATE && !valid) m_err = 1;
        if (valid) begin
            m_ext = (TRANSITION_MODE == M_EXT);
            if (TRANSITION_MODE == M_EXT || TRANSITION_MODE == M_IMM) begin
                do_swap = 1; tgt = int'(REQ_RD_SEGMENT); m_pend = 0;
            end else begin
                m_pend = (TRANSITION_MODE == M_SYNC) ? 1 : (TRANSITION_MODE == M_TIME) ? 2 : 3;
                m_pseg = int'(REQ_RD_SEGMENT);
                m_pval = TRANSITION_VALUE;
                count  = LOOP_END;
            end
        end else begin
            if (m_pend == 1) cond = LOOP_END;
            if (m_pend == 2) cond = (SYS_TIME >= m_pval);
            if (m_pend == 3) cond = edge_seen[m_pval[1:0]];
            if (cond) begin do_swap = 1; tgt = m_pseg; m_pend = 0; end
            else count = LOOP_END;
        end
        if (!do_swap && count && !m_stop) begin
            rep    = int'(REP[m_seg]);
            at_rep = (rep != 255) && (m_cnt == rep);
            if (at_rep && m_ext) begin
                do_swap = 1; tgt = (m_seg + 1) % NSEG;
            end else begin
                if (m_cnt < 255) m_cnt++;
                if (at_rep) m_stop = 1;
            end
        end
        if (do_swap) begin m_seg = tgt; m_cnt = 0; m_stop = 0; m_swp = 1; end
        pin_hist.push_front(GPIO_IN);
        void'(pin_hist.pop_back());
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        model_step();
        @(posedge CLK);
        #1;
        SYS_TIME = SYS_TIME + 64'd1;
    endtask

    task automatic send(input logic [7:0] mode, input int seg, input logic [63:0] val);
        UPDATE = 1; TRANSITION_MODE = mode; REQ_RD_SEGMENT = SEG_W'(seg); TRANSITION_VALUE = val;
        tick();
        UPDATE = 0;
    endtask

    task automatic pulse_loop_end();
        LOOP_END = 1; tick(); LOOP_END = 0;
    endtask

    task automatic do_reset();
        RST = 1; #2;
        model_reset();
        @(posedge CLK); #1;
        RST = 0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({SEGMENT, STOP, BUSY, LOOP_CNT, SWAPPED, ERR} !== '0) begin
            n_fail++;
            $display("FAIL reset_values: got seg=%0d stop=%b busy=%b cnt=%0d swp=%b err=%b, want all zero",
                     SEGMENT, STOP, BUSY, LOOP_CNT, SWAPPED, ERR);
        end
    endtask

    task automatic test_immediate();
        send(M_IMM, 2, 0);
        n_checks++;
        if (SEGMENT !== 2'd2 || SWAPPED !== 1'b1 || BUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL immediate: got seg=%0d swp=%b busy=%b, want 2 1 0", SEGMENT, SWAPPED, BUSY);
        end
        tick();
        n_checks++;
        if (SWAPPED !== 1'b0) begin
            n_fail++; $display("FAIL swapped_one_cycle: got %b want 0", SWAPPED);
        end
    endtask

    task automatic test_sync_idx();
        int busy_cycles = 0;
        send(M_SYNC, 1, 0);
        if (BUSY === 1'b1) busy_cycles++;
        for (int i = 0; i < 9; i++) begin
            tick();
            if (BUSY === 1'b1 && SEGMENT === 2'd2) busy_cycles++;
        end
        n_checks++;
        if (busy_cycles != 10) begin
            n_fail++; $display("FAIL sync_busy_window: got %0d busy cycles want 10", busy_cycles);
        end
        pulse_loop_end();
        n_checks++;
        if (SEGMENT !== 2'd1 || LOOP_CNT !== 8'd0 || BUSY !== 1'b0 || SWAPPED !== 1'b1) begin
            n_fail++;
            $display("FAIL sync_swap: got seg=%0d cnt=%0d busy=%b swp=%b, want 1 0 0 1",
                     SEGMENT, LOOP_CNT, BUSY, SWAPPED);
        end
    endtask

    task automatic test_err();
        send(M_SYNC, 3, 0);
        tick();
        send(8'h05, 1, 0);
        n_checks++;
        if (ERR !== 1'b1 || BUSY !== 1'b1 || SEGMENT !== 2'd1 || SWAPPED !== 1'b0) begin
            n_fail++;
            $display("FAIL bad_mode: got err=%b busy=%b seg=%0d swp=%b, want 1 1 1 0",
                     ERR, BUSY, SEGMENT, SWAPPED);
        end
        tick();
        n_checks++;
        if (ERR !== 1'b0) begin
            n_fail++; $display("FAIL err_one_cycle: got %b want 0", ERR);
        end
        pulse_loop_end();
        n_checks++;
        if (SEGMENT !== 2'd3) begin
            n_fail++; $display("FAIL pending_kept_after_err: got seg=%0d want 3", SEGMENT);
        end
    endtask

    task automatic test_rep_stop();
        logic [REP_W-1:0] held;
        send(M_IMM, 0, 0);
        REP[0] = 8'd2;
        tick();
        pulse_loop_end(); tick();
        n_checks++;
        if (LOOP_CNT !== 8'd1 || STOP !== 1'b0) begin
            n_fail++; $display("FAIL rep_loop1: got cnt=%0d stop=%b want 1 0", LOOP_CNT, STOP);
        end
        pulse_loop_end(); tick();
        n_checks++;
        if (LOOP_CNT !== 8'd2 || STOP !== 1'b0) begin
            n_fail++; $display("FAIL rep_loop2: got cnt=%0d stop=%b want 2 0", LOOP_CNT, STOP);
        end
        pulse_loop_end();
        held = LOOP_CNT;
        n_checks++;
        if (STOP !== 1'b1 || SEGMENT !== 2'd0) begin
            n_fail++; $display("FAIL rep_stop: got stop=%b seg=%0d want 1 0", STOP, SEGMENT);
        end
        pulse_loop_end(); pulse_loop_end();
        n_checks++;
        if (STOP !== 1'b1 || LOOP_CNT !== held || SEGMENT !== 2'd0 || SWAPPED !== 1'b0) begin
            n_fail++;
            $display("FAIL rep_hold: got stop=%b cnt=%0d seg=%0d want 1 %0d 0", STOP, LOOP_CNT, SEGMENT, held);
        end
    endtask

    task automatic test_ext();
        logic [SEG_W-1:0] exp_seg;
        REP = '0;
        send(M_EXT, 0, 0);
        n_checks++;
        if (SEGMENT !== 2'd0 || STOP !== 1'b0 || SWAPPED !== 1'b1) begin
            n_fail++; $display("FAIL ext_start: got seg=%0d stop=%b swp=%b want 0 0 1", SEGMENT, STOP, SWAPPED);
        end
        exp_seg = 2'd0;
        for (int i = 0; i < 4; i++) begin
            tick();
            pulse_loop_end();
            exp_seg = exp_seg + 2'd1;
            n_checks++;
            if (SEGMENT !== exp_seg || SWAPPED !== 1'b1) begin
                n_fail++;
                $display("FAIL ext_advance_%0d: got seg=%0d swp=%b want %0d 1", i, SEGMENT, SWAPPED, exp_seg);
            end
        end
    endtask

    task automatic test_gpio_replace();
        bit   early = 0;
        int   n = 0;
        send(M_IMM, 0, 0);
        send(M_TIME, 3, SYS_TIME + 64'd20);
        for (int i = 0; i < 5; i++) tick();
        send(M_GPIO, 2, 64'd1);
        for (int i = 0; i < 30; i++) begin
            tick();
            if (SWAPPED !== 1'b0) early = 1;
        end
        n_checks++;
        if (early || BUSY !== 1'b1 || SEGMENT !== 2'd0) begin
            n_fail++;
            $display("FAIL replaced_time_req: got early=%b busy=%b seg=%0d want 0 1 0", early, BUSY, SEGMENT);
        end
        GPIO_IN[1] = 1'b1;
        while (n < 10) begin
            tick(); n++;
            if (SWAPPED === 1'b1) break;
        end
        n_checks++;
        if (n != 3 || SEGMENT !== 2'd2 || BUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL gpio_latency: got %0d cycles seg=%0d busy=%b want 3 2 0", n, SEGMENT, BUSY);
        end
        GPIO_IN = '0;
    endtask

    task automatic test_reset_mid_wait();
        bit swapped_late = 0;
        send(M_IMM, 1, 0);
        send(M_TIME, 3, SYS_TIME + 64'd10);
        tick(); tick();
        #2; RST = 1; #1;
        n_checks++;
        if ({SEGMENT, STOP, BUSY, LOOP_CNT, SWAPPED, ERR} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got seg=%0d stop=%b busy=%b cnt=%0d swp=%b err=%b want all zero",
                     SEGMENT, STOP, BUSY, LOOP_CNT, SWAPPED, ERR);
        end
        model_reset();
        @(posedge CLK); #1;
        RST = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (SWAPPED !== 1'b0 || SEGMENT !== 2'd0) swapped_late = 1;
        end
        n_checks++;
        if (swapped_late) begin
            n_fail++; $display("FAIL reset_discards_pending: got a swap after reset, want none");
        end
    endtask

    task automatic test_saturate();
        REP[0] = 8'hFF;
        send(M_IMM, 0, 0);
        LOOP_END = 1;
        for (int i = 0; i < 260; i++) tick();
        LOOP_END = 0;
        n_checks++;
        if (LOOP_CNT !== 8'hFF || STOP !== 1'b0 || SEGMENT !== 2'd0) begin
            n_fail++;
            $display("FAIL saturate: got cnt=%0d stop=%b seg=%0d want 255 0 0", LOOP_CNT, STOP, SEGMENT);
        end
    endtask

    task automatic test_random();
        logic [7:0] modes [6] = '{M_SYNC, M_TIME, M_GPIO, M_EXT, M_IMM, 8'h37};
        logic [15:0] got, exp;
        int bad = 0;
        for (int c = 0; c < 3000; c++) begin
            UPDATE           = ($urandom_range(0, 7) == 0);
            TRANSITION_MODE  = modes[$urandom_range(0, 5)];
            REQ_RD_SEGMENT   = SEG_W'($urandom_range(0, NSEG - 1));
            TRANSITION_VALUE = (TRANSITION_MODE == M_TIME) ?
                               SYS_TIME + 64'($urandom_range(0, 40)) - 64'd5 :
                               64'($urandom_range(0, 3));
            LOOP_END         = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 5) == 0) GPIO_IN[$urandom_range(0, GW - 1)] ^= 1'b1;
            if ($urandom_range(0, 60) == 0)
                REP[$urandom_range(0, NSEG - 1)] = ($urandom_range(0, 4) == 0) ? 8'hFF
                                                   : 8'($urandom_range(0, 3));
            tick();
            got = {SEGMENT, STOP, BUSY, LOOP_CNT, SWAPPED, ERR, 2'b00};
            exp = {SEG_W'(m_seg), m_stop, (m_pend != 0), REP_W'(m_cnt), m_swp, m_err, 2'b00};
            n_checks++;
            if (got !== exp) begin
                n_fail++; bad++;
                if (bad <= 10)
                    $display("FAIL random_cycle_%0d: got seg=%0d stop=%b busy=%b cnt=%0d swp=%b err=%b, want seg=%0d stop=%b busy=%b cnt=%0d swp=%b err=%b",
                             c, SEGMENT, STOP, BUSY, LOOP_CNT, SWAPPED, ERR,
                             m_seg, m_stop, (m_pend != 0), m_cnt, m_swp, m_err);
            end
        end
        UPDATE = 0; LOOP_END = 0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_immediate();
        test_sync_idx();
        test_err();
        test_rep_stop();
        test_ext();
        test_gpio_replace();
        test_reset_mid_wait();
        test_saturate();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
